// File: rtl/op_cache_calc_p.sv
// -----------------------------------------------------------------------------
// op_cache_calc_p
//
// Opcode-cache calculator. In load mode, (opcode, value) pairs are appended to
// a DEPTH-entry instruction cache. In execute mode, one cached instruction is
// replayed per enabled clock into a RES_W-bit accumulator. Replay wraps back
// to a programmable loop-start index, which a JMP instruction can set.
//
// Build option:
//   OP_CACHE_SAT_EN  defined   -> ADD/ADDP/MULP clamp to max on overflow,
//                                 and SUB clamps to 0 on borrow
//                    undefined -> results wrap modulo 2^RES_W
//
// Ports:
//   clk           clock; every state update happens on posedge
//   reset         asynchronous, active-high clear of all state
//   en            operation qualifier (0 = idle cycle)
//   mode          0 = load, 1 = execute
//   op_code       opcode to store (load mode)
//   value         immediate to store (load mode)
//   result        accumulator
//   result_valid  pulse: an instruction executed this cycle
//   overflow      last executed arithmetic op left the representable range
//   invalid_op    pulse: rejected load or rejected JMP
//   cache_full    level: cache holds DEPTH entries
//   cache_count   number of entries stored
//   exec_index    index of the next instruction to execute
// -----------------------------------------------------------------------------
module op_cache_calc_p #(
    parameter int RES_W = 10,
    parameter int VAL_W = 4,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       mode,
    input  logic [2:0]                 op_code,
    input  logic [VAL_W-1:0]           value,
    output logic [RES_W-1:0]           result,
    output logic                       result_valid,
    output logic                       overflow,
    output logic                       invalid_op,
    output logic                       cache_full,
    output logic [$clog2(DEPTH+1)-1:0] cache_count,
    output logic [$clog2(DEPTH)-1:0]   exec_index
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    // Wide enough for result*prev + v without loss
    localparam int FW    = 2 * RES_W + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [RES_W-1:0] RES_MAX  = {RES_W{1'b1}};

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDP = 3'b001;
    localparam logic [2:0] OP_MULP = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_POPC = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_BAD  = 3'b111;

    // Number of set bits in x
    function automatic logic [RES_W-1:0] popcount(input logic [RES_W-1:0] x);
        logic [RES_W-1:0] cnt;
        cnt = {RES_W{1'b0}};
        for (int i = 0; i < RES_W; i++) begin
            cnt = cnt + RES_W'(x[i]);
        end
        return cnt;
    endfunction

    logic [2:0]       r_op  [DEPTH];
    logic [VAL_W-1:0] r_val [DEPTH];

    logic [RES_W-1:0] r_result;
    logic [RES_W-1:0] r_prev;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_exec_index;
    logic [IDX_W-1:0] r_loop_start;
    logic             r_overflow;
    logic             r_invalid;
    logic             r_valid;
    logic             r_full;

    logic             w_load;
    logic             w_load_ok;
    logic             w_exec;
    logic [2:0]       w_op_sel;
    logic [VAL_W-1:0] w_val_sel;
    logic [RES_W-1:0] w_v;
    logic [FW-1:0]    w_full;
    logic             w_arith;
    logic             w_borrow;
    logic [RES_W-1:0] w_res_next;
    logic             w_ovf_next;
    logic             w_jmp_ok;
    logic             w_jmp_bad;
    logic [IDX_W-1:0] w_loop_next;
    logic [CNT_W-1:0] w_idx_inc;
    logic [IDX_W-1:0] w_idx_next;

    assign w_load    = en & ~mode;
    assign w_load_ok = w_load & (op_code != OP_BAD) & (r_count != CNT_FULL);
    assign w_exec    = en & mode & (r_count != {CNT_W{1'b0}});
    assign w_op_sel  = r_op[r_exec_index];
    assign w_val_sel = r_val[r_exec_index];

    // Execute datapath: next accumulator, overflow, JMP target and next index
    always_comb begin
        w_v         = RES_W'(w_val_sel);
        w_full      = {FW{1'b0}};
        w_arith     = 1'b0;
        w_borrow    = 1'b0;
        w_res_next  = r_result;
        w_ovf_next  = r_overflow;
        w_jmp_ok    = 1'b0;
        w_jmp_bad   = 1'b0;
        case (w_op_sel)
            OP_ADD: begin
                w_full  = FW'(r_result) + FW'(w_v);
                w_arith = 1'b1;
            end
            OP_ADDP: begin
                w_full  = FW'(r_result) + FW'(r_prev) + FW'(w_v);
                w_arith = 1'b1;
            end
            OP_MULP: begin
                w_full  = FW'(r_result) * FW'(r_prev) + FW'(w_v);
                w_arith = 1'b1;
            end
            OP_SUB: begin
                w_borrow   = (r_result < w_v);
                w_ovf_next = w_borrow;
`ifdef OP_CACHE_SAT_EN
                w_res_next = w_borrow ? {RES_W{1'b0}} : (r_result - w_v);
`else
                w_res_next = r_result - w_v;
`endif
            end
            OP_POPC: begin
                w_res_next = popcount(r_result);
                w_ovf_next = 1'b0;
            end
            OP_NOT: begin
                w_res_next = ~r_result;
                w_ovf_next = 1'b0;
            end
            OP_JMP: begin
                w_ovf_next = 1'b0;
                // Target must address an entry that already exists
                w_jmp_ok   = (32'(w_val_sel) < 32'(r_count));
                w_jmp_bad  = ~w_jmp_ok;
            end
            default: begin
                // 3'b111 is never stored; treat defensively as a no-op
                w_res_next = r_result;
                w_ovf_next = 1'b0;
            end
        endcase

        if (w_arith) begin
            w_ovf_next = (w_full[FW-1:RES_W] != {(FW-RES_W){1'b0}});
`ifdef OP_CACHE_SAT_EN
            w_res_next = w_ovf_next ? RES_MAX : w_full[RES_W-1:0];
`else
            w_res_next = w_full[RES_W-1:0];
`endif
        end else begin
            w_ovf_next = w_ovf_next;
        end

        // A JMP in the last slot must redirect the wrap on this same edge
        w_loop_next = w_jmp_ok ? IDX_W'(w_val_sel) : r_loop_start;
        w_idx_inc   = CNT_W'(r_exec_index) + CNT_ONE;
        if (w_idx_inc == r_count) begin
            w_idx_next = w_loop_next;
        end else begin
            w_idx_next = w_idx_inc[IDX_W-1:0];
        end
    end

    // Instruction cache storage; contents need no reset
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_op[r_count[IDX_W-1:0]]  <= op_code;
            r_val[r_count[IDX_W-1:0]] <= value;
        end
    end

    // Control and accumulator state with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result     <= {RES_W{1'b0}};
            r_prev       <= {RES_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_exec_index <= {IDX_W{1'b0}};
            r_loop_start <= {IDX_W{1'b0}};
            r_overflow   <= 1'b0;
            r_invalid    <= 1'b0;
            r_valid      <= 1'b0;
            r_full       <= 1'b0;
        end else begin
            r_invalid <= 1'b0;
            r_valid   <= 1'b0;
            if (w_load) begin
                if (w_load_ok) begin
                    r_count <= r_count + CNT_ONE;
                    r_full  <= ((r_count + CNT_ONE) == CNT_FULL);
                end else begin
                    r_invalid <= 1'b1;
                end
            end else if (w_exec) begin
                r_valid      <= 1'b1;
                r_prev       <= r_result;
                r_result     <= w_res_next;
                r_overflow   <= w_ovf_next;
                r_invalid    <= w_jmp_bad;
                r_loop_start <= w_loop_next;
                r_exec_index <= w_idx_next;
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_valid;
    assign overflow     = r_overflow;
    assign invalid_op   = r_invalid;
    assign cache_full   = r_full;
    assign cache_count  = r_count;
    assign exec_index   = r_exec_index;

endmodule

// File: tb/tb_op_cache_calc_p.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for op_cache_calc_p (default parameters).
// -----------------------------------------------------------------------------
module tb_op_cache_calc_p;

    logic        clk;
    logic        reset;
    logic        en;
    logic        mode;
    logic [2:0]  op_code;
    logic [3:0]  value;
    logic [9:0]  result;
    logic        result_valid;
    logic        overflow;
    logic        invalid_op;
    logic        cache_full;
    logic [5:0]  cache_count;
    logic [4:0]  exec_index;

    int vectors     = 0;
    int miscompares = 0;

    op_cache_calc_p dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mode         (mode),
        .op_code      (op_code),
        .value        (value),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow),
        .invalid_op   (invalid_op),
        .cache_full   (cache_full),
        .cache_count  (cache_count),
        .exec_index   (exec_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, sample 1 time unit after posedge
    task automatic step(input logic e, input logic m, input logic [2:0] op, input logic [3:0] v);
        @(negedge clk);
        en = e; mode = m; op_code = op; value = v;
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [2:0] op, input logic [3:0] v);
        step(1'b1, 1'b0, op, v);
    endtask

    task automatic ex();
        step(1'b1, 1'b1, 3'b000, 4'd0);
    endtask

    // Asynchronous pulse placed between clock edges
    task automatic do_reset();
        @(negedge clk);
        en = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 1'b0; op_code = 3'b000; value = 4'd0;
        #12;
        reset = 1'b0;
        #1;
        chk("rst_result", result, 0);
        chk("rst_count", cache_count, 0);
        chk("rst_index", exec_index, 0);
        chk("rst_full", cache_full, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_invalid", invalid_op, 0);
        chk("rst_ovf", overflow, 0);

        // ADD 5, ADD 3, execute x3
        ld(3'b000, 4'd5);
        ld(3'b000, 4'd3);
        chk("cnt2", cache_count, 2);
        ex(); chk("add_r1", result, 5);  chk("add_v1", result_valid, 1); chk("add_i1", exec_index, 1);
        ex(); chk("add_r2", result, 8);  chk("add_v2", result_valid, 1); chk("add_i2", exec_index, 0);
        ex(); chk("add_r3", result, 13); chk("add_v3", result_valid, 1); chk("add_i3", exec_index, 1);
        step(1'b0, 1'b1, 3'b000, 4'd0);
        chk("idle_valid", result_valid, 0); chk("idle_result", result, 13);
        ld(3'b111, 4'd1);
        chk("bad_op_inv", invalid_op, 1); chk("bad_op_cnt", cache_count, 2);
        step(1'b0, 1'b0, 3'b000, 4'd0);
        chk("bad_op_pulse", invalid_op, 0);

        // Overflow: ADD 3, NOT -> 1020, ADD 7, SUB 4
        do_reset();
        ld(3'b000, 4'd3); ld(3'b101, 4'd0); ld(3'b000, 4'd7); ld(3'b011, 4'd4);
        ex(); ex();
        chk("not_1020", result, 1020); chk("not_ovf", overflow, 0);
        ex();
        chk("add7_ovf", overflow, 1);
`ifdef OP_CACHE_SAT_EN
        chk("add7_res", result, 1023);
        ex(); chk("sub4_res", result, 1019); chk("sub4_ovf", overflow, 0);
`else
        chk("add7_res", result, 3);
        ex(); chk("sub4_res", result, 1023); chk("sub4_ovf", overflow, 1);
`endif
        step(1'b0, 1'b0, 3'b000, 4'd0);
        chk("ovf_hold", overflow, 1'b`ifdef OP_CACHE_SAT_EN 0 `else 1 `endif);

        // Borrow: 2 - 5
        do_reset();
        ld(3'b000, 4'd2); ld(3'b011, 4'd5);
        ex(); chk("sub_pre", result, 2);
        ex(); chk("sub5_ovf", overflow, 1); chk("sub5_idx", exec_index, 0);
`ifdef OP_CACHE_SAT_EN
        chk("sub5_res", result, 0);
`else
        chk("sub5_res", result, 1021);
`endif

        // JMP loop {ADD 1, JMP 1, NOT 0}
        do_reset();
        ld(3'b000, 4'd1); ld(3'b110, 4'd1); ld(3'b101, 4'd0);
        ex(); chk("jl_r1", result, 1);
        ex(); chk("jl_r2", result, 1); chk("jl_inv2", invalid_op, 0); chk("jl_v2", result_valid, 1);
        ex(); chk("jl_r3", result, 1022); chk("jl_i3", exec_index, 1);
        ex(); chk("jl_r4", result, 1022); chk("jl_i4", exec_index, 2);
        ex(); chk("jl_r5", result, 1); chk("jl_i5", exec_index, 1);

        // Rejected JMP 9 with count 3, as the last entry
        do_reset();
        ld(3'b000, 4'd1); ld(3'b101, 4'd0); ld(3'b110, 4'd9);
        ex(); ex(); ex();
        chk("jbad_inv", invalid_op, 1); chk("jbad_valid", result_valid, 1);
        chk("jbad_res", result, 1022); chk("jbad_idx", exec_index, 0);
        ld(3'b000, 4'd2);
        chk("late_load_cnt", cache_count, 4); chk("late_load_idx", exec_index, 0);

        // prev/MULP/ADDP/NOT/POPC chain
        do_reset();
        ld(3'b000, 4'd3); ld(3'b000, 4'd1); ld(3'b010, 4'd2);
        ld(3'b001, 4'd0); ld(3'b101, 4'd0); ld(3'b100, 4'd0);
        ex(); ex(); chk("pre_mulp", result, 4);
        ex(); chk("mulp", result, 14); chk("mulp_ovf", overflow, 0);
        ex(); chk("addp", result, 18);
        ex(); chk("not18", result, 1005);
        ex(); chk("popc", result, 8); chk("popc_ovf", overflow, 0);

        // Fill to DEPTH, then one more
        do_reset();
        for (int i = 0; i < 31; i++) ld(3'b000, 4'd1);
        chk("fill31_full", cache_full, 0);
        ld(3'b000, 4'd1);
        chk("fill32_full", cache_full, 1); chk("fill32_cnt", cache_count, 32);
        ld(3'b000, 4'd1);
        chk("fill33_inv", invalid_op, 1); chk("fill33_cnt", cache_count, 32);
        chk("fill33_full", cache_full, 1);

        // Async reset mid-execute
        ex(); ex();
        chk("pre_rst_res", result, 2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_res", result, 0); chk("arst_cnt", cache_count, 0);
        chk("arst_full", cache_full, 0); chk("arst_valid", result_valid, 0);
        chk("arst_idx", exec_index, 0);
        #1;
        reset = 1'b0;
        ex();
        chk("post_rst_valid", result_valid, 0); chk("post_rst_res", result, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
